// File: rtl/pci_arb_pkg.sv
// pci_arb_pkg: shared state encoding and default sizing for the PCI bus arbiter.
package pci_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_BUSY} arb_state_e;
    localparam int DEF_N_MASTERS   = 4;
    localparam int DEF_GNT_TIMEOUT = 16;
    localparam int CNT_W           = 5;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin winner search starting just after the last owner.
module rr_picker #(
    parameter int N  = 4,
    parameter int OW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] last,
    output logic [OW-1:0] winner,
    output logic          any_req
);
    logic [OW-1:0] idx;
    always_comb begin
        winner  = last;
        idx     = '0;
        any_req = ~&req;
        // Scan from farthest to nearest so the nearest requester after last wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = OW'((int'(last) + 1 + k) % N);
            if (!req[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin PCI req/gnt arbiter with grant timeout.
// Define BUS_PARK_EN to park the idle bus on the last owner.
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter int N_MASTERS   = DEF_N_MASTERS,
    parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MASTERS-1:0]         req,
    input  logic                         frame,
    input  logic                         irdy,
    output logic [N_MASTERS-1:0]         gnt,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         bus_busy
);
    localparam int OW = $clog2(N_MASTERS);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 prev_idle_q;
    logic [OW-1:0]        winner;
    logic                 any_req;

    rr_picker #(.N(N_MASTERS), .OW(OW)) u_pick (
        .req     (req),
        .last    (owner_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
`ifdef BUS_PARK_EN
                if (gnt_q != '1) begin
                    // Parked: the owner may start directly, anyone else forces a dead cycle.
                    if (!frame) state_d = ARB_BUSY;
                    else if (any_req && winner == owner_q) begin
                        state_d = ARB_GRANT;
                        cnt_d   = '0;
                    end else if (any_req) gnt_d = '1;
                end else if (any_req) begin
                    owner_d = winner;
                    gnt_d   = ~(N_MASTERS'(1) << winner);
                    state_d = ARB_GRANT;
                    cnt_d   = '0;
                end else gnt_d = ~(N_MASTERS'(1) << owner_q);
`else
                if (any_req) begin
                    owner_d = winner;
                    gnt_d   = ~(N_MASTERS'(1) << winner);
                    state_d = ARB_GRANT;
                    cnt_d   = '0;
                end
`endif
            end
            ARB_GRANT: begin
                if (!frame && prev_idle_q) state_d = ARB_BUSY;
                else if (req[owner_q] || cnt_q == CNT_W'(GNT_TIMEOUT - 1)) begin
                    gnt_d   = '1;
                    state_d = ARB_IDLE;
                end else cnt_d = cnt_q + 1'b1;
            end
            ARB_BUSY: begin
                if (frame && irdy) begin
                    gnt_d   = '1;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                gnt_d   = '1;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '1;
            owner_q     <= OW'(N_MASTERS - 1);
            cnt_q       <= '0;
            prev_idle_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            prev_idle_q <= frame & irdy;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign bus_busy = (state_q == ARB_BUSY);
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed checks of grant, rotation, timeout, busy hold and reset.
module tb_pci_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;
    logic       frame = 1'b1;
    logic       irdy = 1'b1;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       bus_busy;
    int         tests = 0;
    int         fails = 0;

    pci_bus_arbiter #(.N_MASTERS(4), .GNT_TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .frame    (frame),
        .irdy     (irdy),
        .gnt      (gnt),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            assert ($countones(~gnt) <= 1) else begin
                fails++;
                $error("FAIL gnt_onehot: observed %b expected at most one low bit", gnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] e;
        int seq [5] = '{0, 1, 2, 3, 0};
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'hf);
        chk("rst_owner", 32'(owner), 32'd3);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        rst = 1'b0;

        req = 4'b1110;
        tick();
        chk("t1_gnt", 32'(gnt), 32'he);
        chk("t1_owner", 32'(owner), 32'd0);
        frame = 1'b0;
        tick();
        chk("t1_busy_gnt", 32'(gnt), 32'he);
        chk("t1_busy", 32'(bus_busy), 32'd1);
        req = 4'b1111;
        frame = 1'b1;
        tick();
        chk("t1_end_gnt", 32'(gnt), 32'hf);
        chk("t1_end_busy", 32'(bus_busy), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            e = 4'b1111;
            e[seq[i]] = 1'b0;
            tick();
            chk("rot_gnt", 32'(gnt), 32'(e));
            chk("rot_owner", 32'(owner), 32'(seq[i]));
            frame = 1'b0;
            tick();
            tick();
            frame = 1'b1;
            tick();
            chk("rot_dead", 32'(gnt), 32'hf);
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        tick();
        chk("to_gnt", 32'(gnt), 32'hb);
        chk("to_owner", 32'(owner), 32'd2);
        for (int i = 0; i < 15; i++) tick();
        chk("to_held15", 32'(gnt), 32'hb);
        tick();
        chk("to_release", 32'(gnt), 32'hf);
        chk("to_owner_kept", 32'(owner), 32'd2);
        tick();
        chk("to_next_gnt", 32'(gnt), 32'h7);
        chk("to_next_owner", 32'(owner), 32'd3);

        req = 4'b1111;
        tick();
        chk("drop_gnt", 32'(gnt), 32'hf);
        req = 4'b1101;
        tick();
        chk("m1_gnt", 32'(gnt), 32'hd);
        frame = 1'b0;
        tick();
        req = 4'b0101;
        irdy = 1'b0;
        tick();
        chk("m1_hold_a", 32'(gnt), 32'hd);
        req = 4'b1010;
        frame = 1'b1;
        tick();
        chk("m1_hold_b", 32'(gnt), 32'hd);
        chk("m1_busy_irdy", 32'(bus_busy), 32'd1);
        req = 4'b0101;
        irdy = 1'b1;
        tick();
        chk("m1_end", 32'(gnt), 32'hf);
        tick();
        chk("m3_gnt", 32'(gnt), 32'h7);
        chk("m3_owner", 32'(owner), 32'd3);
        frame = 1'b0;
        tick();
        req = 4'b0100;
        frame = 1'b1;
        tick();
        chk("m3_end", 32'(gnt), 32'hf);
        tick();
        chk("wrap_gnt", 32'(gnt), 32'he);
        chk("wrap_owner", 32'(owner), 32'd0);

        frame = 1'b0;
        tick();
        chk("m0_busy", 32'(bus_busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt", 32'(gnt), 32'hf);
        chk("mid_rst_owner", 32'(owner), 32'd3);
        chk("mid_rst_busy", 32'(bus_busy), 32'd0);
        rst = 1'b0;
        frame = 1'b1;
        req = 4'b1111;
        tick();
        chk("idle_gnt", 32'(gnt), 32'hf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
Central PCI bus arbiter.
- Shares the shared AD/C_BE/frame/irdy bus between up to N initiator controllers using active-low req/gnt pairs.
- Decides ownership with round-robin priority.
- Monitors frame and irdy to detect bus-idle and transaction boundaries.
- Withdraws a grant the owner never uses.
- Sits beside the initiator controllers and drives each controller's gnt input.

Parameters:
N_MASTERS, 4, number of requesting initiators (2..8)
GNT_TIMEOUT, 16, clocks a granted-but-idle master gets to assert frame before its grant is withdrawn

Ports:
clk  input  1  bus clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  N_MASTERS  per-master request, active low (bit i = master i)
frame  input  1  PCI frame, active low; bench/board pull-up to 1 when undriven
irdy  input  1  PCI irdy, active low; pulled up when undriven
gnt  output  N_MASTERS  per-master grant, active low, at most one bit 0
owner  output  $clog2(N_MASTERS)  index of current/last granted master
bus_busy  output  1  high while a transaction is in progress (frame==0 or irdy==0)

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst==1 at a rising edge), including mid-transaction:
  - state=IDLE, gnt all 1, owner=N_MASTERS-1 (so master 0 has first priority).
  - bus_busy=0, timeout counter=0.
- bus_idle = frame & irdy (both deasserted).
- Round-robin pick:
  - Search req for the lowest index i such that (owner+1+k) mod N_MASTERS has req==0, k=0..N-1.
  - Wrap-around is mandatory.
  - The current owner has lowest priority.
- State IDLE, gnt all 1:
  - If any req==0, latch winner into owner, drive gnt[owner]=0, go GRANT.
  - Grant latency is 1 clock from the first sampled request.
- State GRANT, waiting for the owner to start:
  - If frame==0 sampled while previous bus_idle held, go BUSY; keep gnt.
  - Else if req[owner]==1 (request dropped), gnt all 1, go IDLE.
  - Else if the timeout counter reaches GNT_TIMEOUT-1, gnt all 1, go IDLE.
  - The counter clears on entry to GRANT.
  - owner is unchanged on timeout, so the next arbitration favours the others.
- State BUSY:
  - bus_busy=1.
  - When frame==0 drops away and the bus is idle (frame==1 and irdy==1 sampled), gnt all 1, go IDLE.
  - The forced dead IDLE cycle is the bus turnaround.
  - gnt is never moved mid-transaction. A req change during BUSY has no effect until the transaction ends.
- Simultaneous events:
  - A request arriving in the same cycle the transaction ends is serviced from IDLE on the next edge.
  - If several requests are pending, exactly one gnt bit goes low (the round-robin winner).
- Invariant: $countones(~gnt) <= 1 at all times. The bench asserts it every cycle.
- owner width is 1 bit minimum when N_MASTERS==2.

Optional Feature:
BUS_PARK_EN
- Defined:
  - In IDLE with no request, gnt[owner] is held 0 (bus parked on last owner).
  - A parked master asserting frame==0 moves IDLE->BUSY directly.
  - Any other master's req leaves gnt all 1 for 1 cycle, then grants the winner.
- Undefined: IDLE always drives gnt all 1, as specified above.

Decomposition:
- Shared package pci_arb_pkg holds:
  - the state enum: ARB_IDLE, ARB_GRANT, ARB_BUSY
  - the default N_MASTERS and GNT_TIMEOUT constants
  - the timeout counter width (5 bits)
- One natural combinational sub-module, rr_picker:
  - inputs: req vector, last owner
  - outputs: winner index, any_req
- The arbiter FSM, timeout counter and gnt register stay in pci_bus_arbiter.

Test Plan:
- Reset, then req=4'b1110: gnt=4'b1110 one clock later, owner=0. Frame low 1 clock then high with irdy high: gnt returns to 4'b1111 next edge (IDLE).
- req=4'b0000 held, each master runs a 2-clock transaction: grants rotate 0,1,2,3,0 with one all-ones gnt cycle between each grant.
- Master 2 granted, frame never asserted, req held low: gnt[2] released after exactly 16 clocks in GRANT. Master 3 also requesting: master 3 is granted next.
- During BUSY of master 1, req=4'b0101 toggles: gnt stays 4'b1101 until the bus goes idle. Next grant goes to master 3, then 0 (wrap).
- rst pulsed high for 1 clock mid-BUSY: gnt=4'b1111, owner=3, bus_busy=0 after that edge. With BUS_PARK_EN, no requests after master 1's transaction: gnt holds 4'b1101.
